// File: rtl/clock_monitor.sv
// Measures high/low time and period of an asynchronous square wave in CLK cycles,
// checks each half-period against EXP_HALF +/- TOL and flags a stuck input.
module clock_monitor #(
  parameter int CNT_W    = 16,
  parameter int EXP_HALF = 5,
  parameter int TOL      = 1,
  parameter int TIMEOUT  = 1000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SIG_IN,
  output logic [CNT_W-1:0] HIGH_T,
  output logic [CNT_W-1:0] LOW_T,
  output logic [CNT_W:0]   PERIOD,
  output logic             MEAS_VALID,
  output logic             IN_TOL,
  output logic             STUCK
);

  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] EXP_C = CNT_W'(EXP_HALF);
  localparam logic [CNT_W-1:0] TOL_C = CNT_W'(TOL);

  typedef enum logic [1:0] {IDLE, WAIT_F, MEAS_L, MEAS_H} state_t;

  state_t           r_state, w_nxt;
  logic             r_s1, r_sig_s, r_sig_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high, r_low;
  logic [CNT_W:0]   r_period;
  logic             r_valid, r_in_tol, r_stuck;

  logic             w_rise, w_fall, w_edge, w_timeout;
  logic             w_cap_high, w_publish;
  logic [CNT_W:0]   w_period;
  logic             w_tol_ok;

  // Unsigned-safe |v - EXP_HALF| <= TOL: subtract in whichever order cannot wrap.
  function automatic logic near(input logic [CNT_W-1:0] v);
    if (v >= EXP_C) near = (v - EXP_C) <= TOL_C;
    else            near = (EXP_C - v) <= TOL_C;
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1    <= 1'b0;
      r_sig_s <= 1'b0;
      r_sig_d <= 1'b0;
    end else begin
      r_s1    <= SIG_IN;
      r_sig_s <= r_s1;
      r_sig_d <= r_sig_s;
    end
  end

  assign w_rise    = r_sig_s & ~r_sig_d;
  assign w_fall    = ~r_sig_s & r_sig_d;
  assign w_edge    = w_rise | w_fall;
  // An edge arriving exactly when the counter saturates takes priority over the timeout.
  assign w_timeout = ~w_edge && (r_cnt == TO_C);

  always_ff @(posedge CLK) begin
    if (RESET)               r_cnt <= '0;
    else if (w_edge)         r_cnt <= CNT_W'(1);
    else if (r_cnt < TO_C)   r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt      = r_state;
    w_cap_high = 1'b0;
    w_publish  = 1'b0;
    if (w_timeout) begin
      w_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:   if (w_rise) w_nxt = WAIT_F;
        WAIT_F: if (w_fall) begin w_cap_high = 1'b1; w_nxt = MEAS_L; end
        MEAS_L: if (w_rise) begin w_publish  = 1'b1; w_nxt = MEAS_H; end
        MEAS_H: if (w_fall) begin w_cap_high = 1'b1; w_nxt = MEAS_L; end
        default: w_nxt = IDLE;
      endcase
    end
  end

  assign w_period = {1'b0, r_high} + {1'b0, r_cnt};
  assign w_tol_ok = near(r_high) && near(r_cnt);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_high   <= '0;
      r_low    <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_in_tol <= 1'b0;
      r_stuck  <= 1'b0;
    end else begin
      r_valid <= w_publish;
      if (w_cap_high) r_high <= r_cnt;
      if (w_publish) begin
        r_low    <= r_cnt;
        r_period <= w_period;
        r_in_tol <= w_tol_ok;
      end
      if (w_timeout) begin
        r_in_tol <= 1'b0;
        r_stuck  <= 1'b1;
      end else if (w_edge) begin
        r_stuck  <= 1'b0;
      end
    end
  end

  assign HIGH_T     = r_high;
  assign LOW_T      = r_low;
  assign PERIOD     = r_period;
  assign MEAS_VALID = r_valid;
  assign IN_TOL     = r_in_tol;
  assign STUCK      = r_stuck;

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: directed scenarios plus random levels, every cycle
// compared against an edge-timestamp reference model.
module tb_clock_monitor;
  localparam int CNT_W = 16, EXP_HALF = 5, TOL = 1, TIMEOUT = 1000;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             SIG_IN = 1'b0;
  logic [CNT_W-1:0] HIGH_T, LOW_T;
  logic [CNT_W:0]   PERIOD;
  logic             MEAS_VALID, IN_TOL, STUCK;

  clock_monitor #(.CNT_W(CNT_W), .EXP_HALF(EXP_HALF), .TOL(TOL), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .SIG_IN(SIG_IN),
    .HIGH_T(HIGH_T), .LOW_T(LOW_T), .PERIOD(PERIOD),
    .MEAS_VALID(MEAS_VALID), .IN_TOL(IN_TOL), .STUCK(STUCK)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: input sample pipeline, timestamp of last edge, and two
  // flags (a rise seen since idle, a high time captured since idle).
  int   c = 0, m_last = 0;
  logic m_p1 = 0, m_s = 0, m_d = 0;
  int   m_high = 0, m_low = 0, m_period = 0;
  int   m_valid = 0, m_intol = 0, m_stuck = 0;
  bit   m_armed = 0, m_hh = 0;

  function automatic bit close(input int v);
    int d;
    d = v - EXP_HALF;
    if (d < 0) d = -d;
    return d <= TOL;
  endfunction

  task automatic model_step(input logic v, input logic r);
    bit rise, fall;
    int len;
    if (r) begin
      m_p1 = 0; m_s = 0; m_d = 0;
      m_high = 0; m_low = 0; m_period = 0;
      m_valid = 0; m_intol = 0; m_stuck = 0;
      m_armed = 0; m_hh = 0;
      m_last = c + 1;
    end else begin
      rise = m_s && !m_d;
      fall = !m_s && m_d;
      len  = c - m_last;
      m_valid = 0;
      if (rise || fall) begin
        m_stuck = 0;
        m_last  = c;
      end
      if (fall && m_armed) begin
        m_high = len;
        m_hh   = 1;
      end
      if (rise) begin
        if (m_hh) begin
          m_low    = len;
          m_period = m_high + len;
          m_valid  = 1;
          m_intol  = (close(m_high) && close(len)) ? 1 : 0;
        end
        m_armed = 1;
      end
      if (!(rise || fall) && len >= TIMEOUT) begin
        m_stuck = 1; m_intol = 0; m_armed = 0; m_hh = 0;
      end
      m_d = m_s; m_s = m_p1; m_p1 = v;
    end
    c++;
  endtask

  task automatic tick(input logic v, input logic r);
    SIG_IN = v;
    RESET  = r;
    @(posedge CLK);
    model_step(v, r);
    #1;
    chk("high",   int'(HIGH_T),     m_high);
    chk("low",    int'(LOW_T),      m_low);
    chk("period", int'(PERIOD),     m_period);
    chk("valid",  int'(MEAS_VALID), m_valid);
    chk("in_tol", int'(IN_TOL),     m_intol);
    chk("stuck",  int'(STUCK),      m_stuck);
  endtask

  task automatic level(input logic v, input int n);
    for (int i = 0; i < n; i++) tick(v, 1'b0);
  endtask

  initial begin
    logic cur;
    int   n;
    // reset with input high to exercise the post-reset pipeline fill
    tick(1'b1, 1'b1); tick(1'b1, 1'b1); tick(1'b0, 1'b1);
    chk("rst_period", int'(PERIOD), 0);
    chk("rst_stuck",  int'(STUCK),  0);
    level(1'b0, 8);

    // nominal 5/5
    for (int i = 0; i < 5; i++) begin level(1'b1, 5); level(1'b0, 5); end
    level(1'b1, 5);
    chk("nom_high", int'(HIGH_T), 5);
    chk("nom_low",  int'(LOW_T),  5);
    chk("nom_per",  int'(PERIOD), 10);
    chk("nom_tol",  int'(IN_TOL), 1);

    // asymmetric 4 high / 7 low
    for (int i = 0; i < 3; i++) begin level(1'b0, 7); level(1'b1, 4); end
    chk("asy_high", int'(HIGH_T), 4);
    chk("asy_low",  int'(LOW_T),  7);
    chk("asy_per",  int'(PERIOD), 11);
    chk("asy_tol",  int'(IN_TOL), 0);

    // stuck high, then resume
    level(1'b1, 1200);
    chk("stk_flag", int'(STUCK),  1);
    chk("stk_high", int'(HIGH_T), 4);
    chk("stk_per",  int'(PERIOD), 11);
    for (int i = 0; i < 2; i++) begin level(1'b0, 5); level(1'b1, 5); end
    chk("res_stuck", int'(STUCK),  0);
    chk("res_per",   int'(PERIOD), 10);
    chk("res_tol",   int'(IN_TOL), 1);

    // levels of exactly TIMEOUT cycles: edge wins
    level(1'b0, TIMEOUT);
    level(1'b1, TIMEOUT);
    level(1'b0, 3);
    chk("to_low",   int'(LOW_T),  TIMEOUT);
    chk("to_high",  int'(HIGH_T), TIMEOUT);
    chk("to_per",   int'(PERIOD), TIMEOUT + 5);
    chk("to_stuck", int'(STUCK),  0);

    // minimum 1/1 pulses
    for (int i = 0; i < 6; i++) begin level(1'b1, 1); level(1'b0, 1); end
    level(1'b1, 4);
    chk("min_high", int'(HIGH_T), 1);
    chk("min_low",  int'(LOW_T),  1);
    chk("min_per",  int'(PERIOD), 2);

    // reset 3 cycles into a low phase
    level(1'b0, 3);
    tick(1'b0, 1'b1);
    chk("mid_rst_high", int'(HIGH_T), 0);
    chk("mid_rst_per",  int'(PERIOD), 0);
    level(1'b0, 2); level(1'b1, 5); level(1'b0, 5); level(1'b1, 5);
    chk("mid_rst_per2", int'(PERIOD), 10);

    // random levels with occasional reset
    cur = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        tick(cur, 1'b1);
      end else begin
        cur = ~cur;
        n = $urandom_range(1, 12);
        level(cur, n);
      end
    end
    level(cur, 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
